// File: rtl/shift_mix_iter_if.sv
// Handshake and data bundle for the shift_mix_iter stage.
// master drives start/dataIn/inverse/skipMix; slave returns dataOut/busy/done.
interface shift_mix_iter_if;
  logic         start;
  logic [127:0] dataIn;
  logic         inverse;
  logic         skipMix;
  logic [127:0] dataOut;
  logic         busy;
  logic         done;

  modport master (
    output start, dataIn, inverse, skipMix,
    input  dataOut, busy, done
  );

  modport slave (
    input  start, dataIn, inverse, skipMix,
    output dataOut, busy, done
  );
endinterface

// File: rtl/shift_mix_iter.sv
// Iterative ShiftRows+MixColumns (or InvMixColumns+InvShiftRows), one column per clock.
// Ports: clk, rst (sync, active-high), bus (slave): start/dataIn/inverse/skipMix in, dataOut/busy/done out.
// Build option: SHIFTMIX_INVERSE_EN builds the inverse path; otherwise inverse is ignored.
module shift_mix_iter (
  input  logic          clk,
  input  logic          rst,
  shift_mix_iter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COL  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] d  [4];
    logic [31:0] o;
    logic [1:0] j1, j2, j3;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i] = c[31-8*i -: 8];
      d[i] = xt(a[i]);
    end
    for (int i = 0; i < 4; i++) begin
      j1 = 2'(i + 1);
      j2 = 2'(i + 2);
      j3 = 2'(i + 3);
      o[31-8*i -: 8] = d[i] ^ d[j1] ^ a[j1]
                     ^ a[j2] ^ a[j3];
    end
    return o;
  endfunction

`ifdef SHIFTMIX_INVERSE_EN
  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  // 0E/0B/0D/09 from x2/x4/x8 chains
  function automatic logic [31:0] inv_mix(input logic [31:0] c);
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] a, x2, x4, x8;
    logic [31:0] o;
    logic [1:0] j1, j2, j3;
    o = '0;
    for (int i = 0; i < 4; i++) begin
      a  = c[31-8*i -: 8];
      x2 = xt(a);
      x4 = xt(x2);
      x8 = xt(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    for (int i = 0; i < 4; i++) begin
      j1 = 2'(i + 1);
      j2 = 2'(i + 2);
      j3 = 2'(i + 3);
      o[31-8*i -: 8] = me[i] ^ mb[j1]
                     ^ md[j2] ^ m9[j3];
    end
    return o;
  endfunction
`endif

  logic [1:0]   state;
  logic [1:0]   col;
  logic [127:0] work;
  logic         mode_inv;
  logic         mode_skip;
  logic [6:0]   base;
  logic [31:0]  cur;
  logic [31:0]  mixed;

  // column c lives at bits [127-32c : 96-32c]; 3-c == ~c
  assign base = {~col, 5'd0};
  assign cur  = work[base +: 32];

`ifdef SHIFTMIX_INVERSE_EN
  assign mixed = mode_inv ? inv_mix(cur) : mix(cur);
`else
  assign mixed = mix(cur);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col         <= 2'd0;
      work        <= '0;
      mode_inv    <= 1'b0;
      mode_skip   <= 1'b0;
      bus.dataOut <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
`ifdef SHIFTMIX_INVERSE_EN
            mode_inv <= bus.inverse;
            work     <= bus.inverse ? bus.dataIn
                      : shift_rows(bus.dataIn);
`else
            mode_inv <= 1'b0;
            work     <= shift_rows(bus.dataIn);
`endif
            mode_skip <= bus.skipMix;
            col       <= 2'd0;
            bus.busy  <= 1'b1;
            state     <= COL;
          end
        end
        COL: begin
          if (!mode_skip)
            work[base +: 32] <= mixed;
          if (col == 2'd3)
            state <= FIN;
          else
            col <= col + 2'd1;
        end
        FIN: begin
`ifdef SHIFTMIX_INVERSE_EN
          bus.dataOut <= mode_inv ? inv_shift_rows(work)
                       : work;
`else
          bus.dataOut <= work;
`endif
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          col      <= 2'd0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
